// File: rtl/alu_arbiter_pkg.sv
// Shared constants and op-code encoding for the two-requester ALU arbiter.
package alu_arbiter_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CTL_W  = 4;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned SHAMT_W = 5;

    // Result returned for op codes 10-15.
    localparam logic [DATA_W-1:0] ILLEGAL_RESULT = 32'h7FFF_FFFF;

    typedef enum logic [CTL_W-1:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_SLL  = 4'd2,
        OP_SLT  = 4'd3,
        OP_SLTU = 4'd4,
        OP_XOR  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_OR   = 4'd8,
        OP_AND  = 4'd9
    } alu_op_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two requesters, the arbiter and one consumer.
interface alu_arbiter_if;
    import alu_arbiter_pkg::*;

    logic              req0_valid;
    logic              req0_ready;
    logic [CTL_W-1:0]  req0_ctl;
    logic [DATA_W-1:0] req0_src1;
    logic [DATA_W-1:0] req0_src2;

    logic              req1_valid;
    logic              req1_ready;
    logic [CTL_W-1:0]  req1_ctl;
    logic [DATA_W-1:0] req1_src1;
    logic [DATA_W-1:0] req1_src2;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_zero;

    logic [CNT_W-1:0]  grant_cnt0;
    logic [CNT_W-1:0]  grant_cnt1;

    // Requesters and consumer side.
    modport master (
        output req0_valid, req0_ctl, req0_src1, req0_src2,
        output req1_valid, req1_ctl, req1_src1, req1_src2,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_zero,
        input  grant_cnt0, grant_cnt1
    );

    // Arbiter side.
    modport slave (
        input  req0_valid, req0_ctl, req0_src1, req0_src2,
        input  req1_valid, req1_ctl, req1_src1, req1_src2,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_zero,
        output grant_cnt0, grant_cnt1
    );

endinterface

// File: rtl/alu_arbiter_alu_core.sv
// Purely combinational 32-bit ALU shared by both requesters.
module alu_core
    import alu_arbiter_pkg::*;
(
    input  logic [CTL_W-1:0]  ctl,
    input  logic [DATA_W-1:0] src1,
    input  logic [DATA_W-1:0] src2,
    output logic [DATA_W-1:0] result
);

    logic [SHAMT_W-1:0] shamt;

    assign shamt = src2[SHAMT_W-1:0];

    // Decode op code and compute result.
    always_comb begin
        result = ILLEGAL_RESULT;
        case (alu_op_e'(ctl))
            OP_ADD:  result = src1 + src2;
            OP_SUB:  result = src1 - src2;
            OP_SLL:  result = src1 << shamt;
            OP_SLT:  result = DATA_W'($signed(src1) < $signed(src2));
            OP_SLTU: result = DATA_W'(src1 < src2);
            OP_XOR:  result = src1 ^ src2;
            OP_SRL:  result = src1 >> shamt;
            OP_SRA:  result = DATA_W'($signed(src1) >>> shamt);
            OP_OR:   result = src1 | src2;
            OP_AND:  result = src1 & src2;
            default: result = ILLEGAL_RESULT;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter feeding a shared ALU into a single registered result slot.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned RR_INIT = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_arbiter_if.slave bus
);

    logic              prio;
    logic              rsp_valid_q;
    logic              rsp_id_q;
    logic [DATA_W-1:0] rsp_result_q;
    logic              rsp_zero_q;
    logic [CNT_W-1:0]  cnt0_q;
    logic [CNT_W-1:0]  cnt1_q;

    logic              slot_free_c;
    logic              win_c;
    logic              accept_c;
    logic [CTL_W-1:0]  ctl_c;
    logic [DATA_W-1:0] src1_c;
    logic [DATA_W-1:0] src2_c;
    logic [DATA_W-1:0] result_c;

    // Slot accepts when empty or being drained this cycle; closed while in reset.
    assign slot_free_c = rst_n && (!rsp_valid_q || bus.rsp_ready);
    assign accept_c    = slot_free_c && (bus.req0_valid || bus.req1_valid);

    // Pick the winner: a lone requester wins, a tie goes to the priority pointer.
    always_comb begin
        win_c = prio;
        if (bus.req0_valid && !bus.req1_valid) begin
            win_c = 1'b0;
        end else if (!bus.req0_valid && bus.req1_valid) begin
            win_c = 1'b1;
        end
    end

    assign bus.req0_ready = accept_c && !win_c;
    assign bus.req1_ready = accept_c && win_c;

    // Route the winner's operands to the ALU.
    always_comb begin
        ctl_c  = bus.req0_ctl;
        src1_c = bus.req0_src1;
        src2_c = bus.req0_src2;
        if (win_c) begin
            ctl_c  = bus.req1_ctl;
            src1_c = bus.req1_src1;
            src2_c = bus.req1_src2;
        end
    end

    alu_core u_alu_core (
        .ctl    (ctl_c),
        .src1   (src1_c),
        .src2   (src2_c),
        .result (result_c)
    );

    // Result slot and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            prio         <= 1'(RR_INIT);
        end else if (accept_c) begin
            rsp_valid_q  <= 1'b1;
            rsp_id_q     <= win_c;
            rsp_result_q <= result_c;
            rsp_zero_q   <= (result_c == '0);
            prio         <= !win_c;
        end else if (rsp_valid_q && bus.rsp_ready) begin
            rsp_valid_q  <= 1'b0;
        end
    end

    // Saturating per-requester grant counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (bus.req0_ready && bus.req0_valid && (cnt0_q != '1)) begin
                cnt0_q <= cnt0_q + CNT_W'(1);
            end
            if (bus.req1_ready && bus.req1_valid && (cnt1_q != '1)) begin
                cnt1_q <= cnt1_q + CNT_W'(1);
            end
        end
    end

    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_zero   = rsp_zero_q;
    assign bus.grant_cnt0 = cnt0_q;
    assign bus.grant_cnt1 = cnt1_q;

endmodule
